// File: rtl/keypad_scanner_param.sv
// Parametrised keypad scanner: one-hot column drive, debounced press/release, key code.
// Ports: clk, rst (sync high), row_in -> col_out, scan_tick, key_code, key_valid,
//   key_held, key_release, multi_key.
module keypad_scanner_param #(
  parameter int NUM_ROWS       = 4,
  parameter int NUM_COLS       = 4,
  parameter int SCAN_DIV       = 27000,
  parameter int DEBOUNCE_SCANS = 4,
  localparam int CODE_W        = $clog2(NUM_ROWS * NUM_COLS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_ROWS-1:0] row_in,
  output logic [NUM_COLS-1:0] col_out,
  output logic                scan_tick,
  output logic [CODE_W-1:0]   key_code,
  output logic                key_valid,
  output logic                key_held,
  output logic                key_release,
  output logic                multi_key
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam int COL_W = $clog2(NUM_COLS);
  localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SCANS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(NUM_COLS - 1);
  localparam logic [NUM_COLS-1:0] COL0  = {{(NUM_COLS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE,
    S_DEBOUNCE,
    S_PRESSED,
    S_RELEASE_DB
  } state_t;

  state_t               r_state;
  logic [NUM_ROWS-1:0]  r_sync1;
  logic [NUM_ROWS-1:0]  r_sync2;
  logic [DIV_W-1:0]     r_div;
  logic [NUM_COLS-1:0]  r_col;
  logic [COL_W-1:0]     r_col_idx;
  logic [CNT_W-1:0]     r_cnt;
  logic [ROW_W-1:0]     r_cand_row;
  logic [CODE_W-1:0]    r_cand_code;
  logic [CODE_W-1:0]    r_key_code;
  logic                 r_valid;
  logic                 r_held;
  logic                 r_rel;
  logic                 r_multi;

  logic                 w_tick;
  logic                 w_any;
  logic                 w_many;
  logic                 w_single;
  logic                 w_same;
  logic                 w_cand_hit;
  logic [ROW_W-1:0]     w_row_idx;
  logic [CODE_W-1:0]    w_new_code;
  logic [NUM_COLS-1:0]  w_col_nxt;
  logic [COL_W-1:0]     w_col_idx_nxt;

  assign w_tick = (r_div == DIV_LAST);

  // Classify the synchronised rows: none, exactly one (with its index), or several.
  always_comb begin
    w_any     = 1'b0;
    w_many    = 1'b0;
    w_row_idx = '0;
    for (int i = 0; i < NUM_ROWS; i++) begin
      if (r_sync2[i]) begin
        if (w_any) w_many = 1'b1;
        w_any     = 1'b1;
        w_row_idx = ROW_W'(i);
      end
    end
  end

  assign w_single   = w_any & ~w_many;
  assign w_same     = w_single & (w_row_idx == r_cand_row);
  assign w_cand_hit = r_sync2[r_cand_row];

  always_comb begin
    w_new_code = CODE_W'(int'(w_row_idx) * NUM_COLS + int'(r_col_idx));
  end

  assign w_col_nxt     = {r_col[NUM_COLS-2:0], r_col[NUM_COLS-1]};
  assign w_col_idx_nxt = (r_col_idx == COL_LAST) ? '0 : r_col_idx + 1'b1;

  // Row synchroniser and dwell divider.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_div   <= '0;
    end else begin
      r_sync1 <= row_in;
      r_sync2 <= r_sync1;
      r_div   <= w_tick ? '0 : r_div + 1'b1;
    end
  end

  // Scan/debounce FSM. The column only moves while idle, so every
  // debounce sample belongs to the column that produced the candidate.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_col       <= COL0;
      r_col_idx   <= '0;
      r_cnt       <= '0;
      r_cand_row  <= '0;
      r_cand_code <= '0;
      r_key_code  <= '0;
      r_valid     <= 1'b0;
      r_held      <= 1'b0;
      r_rel       <= 1'b0;
      r_multi     <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_rel   <= 1'b0;
      r_multi <= 1'b0;
      if (w_tick) begin
        unique case (r_state)
          S_IDLE: begin
            if (w_single) begin
              r_cand_row  <= w_row_idx;
              r_cand_code <= w_new_code;
              if (DEBOUNCE_SCANS == 1) begin
                r_key_code <= w_new_code;
                r_valid    <= 1'b1;
                r_held     <= 1'b1;
                r_cnt      <= '0;
                r_state    <= S_PRESSED;
              end else begin
                r_cnt   <= CNT_ONE;
                r_state <= S_DEBOUNCE;
              end
            end else begin
              r_multi   <= w_many;
              r_col     <= w_col_nxt;
              r_col_idx <= w_col_idx_nxt;
            end
          end
          S_DEBOUNCE: begin
            if (w_same) begin
              if (r_cnt == CNT_LAST) begin
                r_key_code <= r_cand_code;
                r_valid    <= 1'b1;
                r_held     <= 1'b1;
                r_cnt      <= '0;
                r_state    <= S_PRESSED;
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end else begin
              r_cnt     <= '0;
              r_multi   <= w_many;
              r_state   <= S_IDLE;
              r_col     <= w_col_nxt;
              r_col_idx <= w_col_idx_nxt;
            end
          end
          S_PRESSED: begin
            if (!w_cand_hit) begin
              if (DEBOUNCE_SCANS == 1) begin
                r_rel     <= 1'b1;
                r_held    <= 1'b0;
                r_cnt     <= '0;
                r_state   <= S_IDLE;
                r_col     <= w_col_nxt;
                r_col_idx <= w_col_idx_nxt;
              end else begin
                r_cnt   <= CNT_ONE;
                r_state <= S_RELEASE_DB;
              end
            end
          end
          S_RELEASE_DB: begin
            if (w_cand_hit) begin
              r_cnt   <= '0;
              r_state <= S_PRESSED;
            end else if (r_cnt == CNT_LAST) begin
              r_rel     <= 1'b1;
              r_held    <= 1'b0;
              r_cnt     <= '0;
              r_state   <= S_IDLE;
              r_col     <= w_col_nxt;
              r_col_idx <= w_col_idx_nxt;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign col_out     = r_col;
  assign scan_tick   = w_tick;
  assign key_code    = r_key_code;
  assign key_valid   = r_valid;
  assign key_held    = r_held;
  assign key_release = r_rel;
  assign multi_key   = r_multi;

endmodule

// File: tb/tb_keypad_scanner_param.sv
// Bench for keypad_scanner_param: three configurations against a per-cycle
// reference model, plus directed table and hand sequences.
module tb_keypad_scanner_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] row_a;
  logic [2:0] row_b;
  logic [3:0] row_c;

  logic [3:0] col_a;
  logic [4:0] col_b;
  logic [3:0] col_c;
  logic       tick_a, tick_b, tick_c;
  logic [3:0] code_a, code_b, code_c;
  logic       valid_a, valid_b, valid_c;
  logic       held_a, held_b, held_c;
  logic       rel_a, rel_b, rel_c;
  logic       multi_a, multi_b, multi_c;

  keypad_scanner_param #(
    .NUM_ROWS(4), .NUM_COLS(4), .SCAN_DIV(4), .DEBOUNCE_SCANS(3)
  ) u_a (
    .clk(clk), .rst(rst), .row_in(row_a), .col_out(col_a),
    .scan_tick(tick_a), .key_code(code_a), .key_valid(valid_a),
    .key_held(held_a), .key_release(rel_a), .multi_key(multi_a)
  );

  keypad_scanner_param #(
    .NUM_ROWS(3), .NUM_COLS(5), .SCAN_DIV(4), .DEBOUNCE_SCANS(3)
  ) u_b (
    .clk(clk), .rst(rst), .row_in(row_b), .col_out(col_b),
    .scan_tick(tick_b), .key_code(code_b), .key_valid(valid_b),
    .key_held(held_b), .key_release(rel_b), .multi_key(multi_b)
  );

  keypad_scanner_param #(
    .NUM_ROWS(4), .NUM_COLS(4), .SCAN_DIV(3), .DEBOUNCE_SCANS(1)
  ) u_c (
    .clk(clk), .rst(rst), .row_in(row_c), .col_out(col_c),
    .scan_tick(tick_c), .key_code(code_c), .key_valid(valid_c),
    .key_held(held_c), .key_release(rel_c), .multi_key(multi_c)
  );

  int tests = 0;
  int fails = 0;

  int P_R  [3] = '{4, 3, 4};
  int P_C  [3] = '{4, 5, 4};
  int P_SD [3] = '{4, 4, 3};
  int P_DS [3] = '{3, 3, 1};

  // Reference model: "held" plus a streak of agreeing samples describes the key;
  // a streak of 0 means nothing is pending.
  int         m_div [3];
  int         m_col [3];
  int         m_held[3];
  int         m_strk[3];
  int         m_crow[3];
  int         m_code[3];
  int         m_pend[3];
  logic [3:0] m_s1  [3];
  logic [3:0] m_s2  [3];
  bit         m_v [3];
  bit         m_r [3];
  bit         m_m [3];

  int cv[3];
  int cr[3];
  int cm[3];

  task automatic check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_step(int d, bit r_i, logic [3:0] rin);
    logic [3:0] smp;
    int n;
    int row;
    bit adv;
    if (r_i) begin
      m_div[d] = 0; m_col[d] = 0; m_held[d] = 0; m_strk[d] = 0;
      m_crow[d] = 0; m_code[d] = 0; m_pend[d] = 0;
      m_s1[d] = 0; m_s2[d] = 0;
      m_v[d] = 0; m_r[d] = 0; m_m[d] = 0;
      return;
    end
    smp = m_s2[d];
    n = $countones(smp);
    row = 0;
    for (int i = 0; i < 4; i++) if (smp[i]) row = i;
    m_v[d] = 0; m_r[d] = 0; m_m[d] = 0;
    adv = 0;
    if (m_div[d] == P_SD[d] - 1) begin
      if (m_held[d] == 0) begin
        if (m_strk[d] == 0) begin
          if (n == 1) begin
            m_crow[d] = row;
            m_pend[d] = row * P_C[d] + m_col[d];
            m_strk[d] = 1;
          end else begin
            m_m[d] = (n > 1);
            adv = 1;
          end
        end else if (n == 1 && row == m_crow[d]) begin
          m_strk[d]++;
        end else begin
          m_strk[d] = 0;
          m_m[d] = (n > 1);
          adv = 1;
        end
        if (m_strk[d] == P_DS[d]) begin
          m_code[d] = m_pend[d];
          m_v[d] = 1;
          m_held[d] = 1;
          m_strk[d] = 0;
        end
      end else begin
        if (smp[m_crow[d]]) m_strk[d] = 0;
        else m_strk[d]++;
        if (m_strk[d] == P_DS[d]) begin
          m_r[d] = 1;
          m_held[d] = 0;
          m_strk[d] = 0;
          adv = 1;
        end
      end
    end
    if (adv) m_col[d] = (m_col[d] + 1) % P_C[d];
    m_div[d] = (m_div[d] == P_SD[d] - 1) ? 0 : m_div[d] + 1;
    m_s2[d] = m_s1[d];
    m_s1[d] = rin;
  endtask

  function automatic int exp_vec(int d);
    logic [13:0] e;
    logic [4:0] c;
    c = 5'(1 << m_col[d]);
    e = {c, (m_div[d] == P_SD[d] - 1), 4'(m_code[d]),
         m_v[d], m_held[d] != 0, m_r[d], m_m[d]};
    return int'(e);
  endfunction

  task automatic step();
    logic [13:0] a;
    @(posedge clk);
    model_step(0, rst, row_a);
    model_step(1, rst, {1'b0, row_b});
    model_step(2, rst, row_c);
    #1;
    a = {1'b0, col_a, tick_a, code_a, valid_a, held_a, rel_a, multi_a};
    check("model_a", int'(a), exp_vec(0));
    a = {col_b, tick_b, code_b, valid_b, held_b, rel_b, multi_b};
    check("model_b", int'(a), exp_vec(1));
    a = {1'b0, col_c, tick_c, code_c, valid_c, held_c, rel_c, multi_c};
    check("model_c", int'(a), exp_vec(2));
    cv[0] += valid_a; cr[0] += rel_a; cm[0] += multi_a;
    cv[1] += valid_b; cr[1] += rel_b; cm[1] += multi_b;
    cv[2] += valid_c; cr[2] += rel_c; cm[2] += multi_c;
  endtask

  task automatic clr_counts();
    for (int d = 0; d < 3; d++) begin
      cv[d] = 0; cr[d] = 0; cm[d] = 0;
    end
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic logic [3:0] rnd_rows(int nr);
    int k;
    logic [3:0] v;
    k = $urandom_range(0, 19);
    if (k < 8) v = 4'd0;
    else if (k < 16) v = 4'(1 << $urandom_range(0, nr - 1));
    else v = 4'($urandom);
    return v & 4'((1 << nr) - 1);
  endfunction

  typedef struct {
    logic [3:0] rows;
    int         dwells;
    logic [3:0] col;
    int         code;
    bit         held;
    int         nv;
    int         nr;
    int         nm;
  } vec_t;

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{4'b0000, 1, 4'b0010, 0, 1'b0, 0, 0, 0};
    tbl[1]  = '{4'b0010, 3, 4'b0010, 5, 1'b1, 1, 0, 0};
    tbl[2]  = '{4'b0010, 7, 4'b0010, 5, 1'b1, 0, 0, 0};
    tbl[3]  = '{4'b0000, 3, 4'b0100, 5, 1'b0, 0, 1, 0};
    tbl[4]  = '{4'b0000, 1, 4'b1000, 5, 1'b0, 0, 0, 0};
    tbl[5]  = '{4'b0010, 2, 4'b1000, 5, 1'b0, 0, 0, 0};
    tbl[6]  = '{4'b0000, 4, 4'b1000, 5, 1'b0, 0, 0, 0};
    tbl[7]  = '{4'b0010, 3, 4'b1000, 7, 1'b1, 1, 0, 0};
    tbl[8]  = '{4'b0000, 3, 4'b0001, 7, 1'b0, 0, 1, 0};
    tbl[9]  = '{4'b0011, 4, 4'b0001, 7, 1'b0, 0, 0, 4};
    tbl[10] = '{4'b0000, 1, 4'b0010, 7, 1'b0, 0, 0, 0};
    tbl[11] = '{4'b0100, 3, 4'b0010, 9, 1'b1, 1, 0, 0};

    rst = 1'b1;
    row_a = '0; row_b = '0; row_c = '0;
    run(3);
    rst = 1'b0;
    check("reset_col", int'(col_a), 1);
    check("reset_code", int'(code_a), 0);
    check("reset_strobes", int'({valid_a, held_a, rel_a, multi_a, tick_a}), 0);

    for (int i = 0; i < 12; i++) begin
      clr_counts();
      row_a = tbl[i].rows;
      run(tbl[i].dwells * 4);
      check($sformatf("tbl%0d_col", i), int'(col_a), int'(tbl[i].col));
      check($sformatf("tbl%0d_code", i), int'(code_a), tbl[i].code);
      check($sformatf("tbl%0d_held", i), int'(held_a), int'(tbl[i].held));
      check($sformatf("tbl%0d_nvalid", i), cv[0], tbl[i].nv);
      check($sformatf("tbl%0d_nrel", i), cr[0], tbl[i].nr);
      check($sformatf("tbl%0d_nmulti", i), cm[0], tbl[i].nm);
    end

    // Reset while a key is held on column 1.
    rst = 1'b1;
    row_a = '0;
    clr_counts();
    step();
    rst = 1'b0;
    check("rst_held_col", int'(col_a), 1);
    check("rst_held_held", int'(held_a), 0);
    check("rst_held_code", int'(code_a), 0);
    run(16);
    check("rst_held_norel", cr[0] + cv[0], 0);

    // 3x5 instance: row 2 on column 4, then release wraps to column 0.
    rst = 1'b1;
    step();
    rst = 1'b0;
    run(16);
    check("b_col4", int'(col_b), 5'b10000);
    clr_counts();
    row_b = 3'b100;
    run(12);
    check("b_code", int'(code_b), 14);
    check("b_held", int'(held_b), 1);
    check("b_nvalid", cv[1], 1);
    clr_counts();
    row_b = 3'b000;
    run(12);
    check("b_wrap_col", int'(col_b), 1);
    check("b_nrel", cr[1], 1);

    // Random traffic on all three instances.
    for (int s = 0; s < 150; s++) begin
      row_a = rnd_rows(4);
      row_b = 3'(rnd_rows(3));
      row_c = rnd_rows(4);
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
      end
      run($urandom_range(1, 40));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
